// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle ARM main controller:
// state enumeration, control-word layout and the state decode helpers.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } statetype_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_RD2    = 2'b00;
    localparam logic [1:0] SRCB_EXTIMM = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    // Raw per-state control word; branch and aluop never leave the controller.
    typedef struct packed {
        logic       irwrite;
        logic       nextpc;
        logic       regw;
        logic       memw;
        logic       branch;
        logic       aluop;
        logic       adrsrc;
        logic [1:0] resultsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(input statetype_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.irwrite   = 1'b1;
                c.nextpc    = 1'b1;
                c.alusrca   = 1'b1;
                c.alusrcb   = SRCB_FOUR;
                c.resultsrc = RES_ALURESULT;
            end
            DECODE: begin
                c.alusrca   = 1'b1;
                c.alusrcb   = SRCB_FOUR;
                c.resultsrc = RES_ALURESULT;
            end
            MEMADR:   c.alusrcb = SRCB_EXTIMM;
            MEMREAD:  c.adrsrc  = 1'b1;
            MEMWB: begin
                c.resultsrc = RES_DATA;
                c.regw      = 1'b1;
            end
            MEMWRITE: begin
                c.adrsrc = 1'b1;
                c.memw   = 1'b1;
            end
            EXECUTER: c.aluop = 1'b1;
            EXECUTEI: begin
                c.alusrcb = SRCB_EXTIMM;
                c.aluop   = 1'b1;
            end
            ALUWB:    c.regw = 1'b1;
            BRANCH: begin
                c.alusrcb   = SRCB_EXTIMM;
                c.resultsrc = RES_ALURESULT;
                c.branch    = 1'b1;
            end
            default:  c = '0;
        endcase
        return c;
    endfunction

    // Op=11 is undefined and falls straight back to FETCH without side effects.
    function automatic statetype_t next_state(input statetype_t s,
                                              input logic [1:0] op,
                                              input logic [5:0] funct);
        statetype_t n;
        n = FETCH;
        case (s)
            FETCH: n = DECODE;
            DECODE: begin
                case (op)
                    OP_MEM:  n = MEMADR;
                    OP_DP:   n = funct[5] ? EXECUTEI : EXECUTER;
                    OP_BR:   n = BRANCH;
                    default: n = FETCH;
                endcase
            end
            MEMADR:   n = funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  n = MEMWB;
            EXECUTER: n = ALUWB;
            EXECUTEI: n = ALUWB;
            default:  n = FETCH;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction-field inputs and datapath control outputs of the main controller.
// The controller is the master; the datapath is the slave.
interface multicycle_controller_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       PCS;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic [1:0] FlagW;
    logic       IRWrite;
    logic       AdrSrc;
    logic [1:0] ResultSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUControl;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;

    modport master (
        input  Op, Funct, Rd,
        output PCS, NextPC, RegW, MemW, FlagW, IRWrite, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc
    );

    modport slave (
        output Op, Funct, Rd,
        input  PCS, NextPC, RegW, MemW, FlagW, IRWrite, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc
    );
endinterface

// File: rtl/multicycle_controller_main_fsm.sv
// Instruction sequencer: state register plus a control word registered
// from the next state, so every control output comes straight from a flop.
module main_fsm
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    output statetype_t state,
    output ctrl_t      ctrl
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            ctrl  <= state_ctrl(FETCH);
        end else begin
            state <= next_state(state, op, funct);
            ctrl  <= state_ctrl(next_state(state, op, funct));
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM main controller: sequencer plus ALU decode, PC-source and
// immediate/register source selects. Write strobes are forced low while reset is high.
module multicycle_controller
    import arm_ctrl_pkg::*;
#(
    parameter logic [3:0] PC_REG = 4'd15
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus,
    output statetype_t              state
);

    ctrl_t      ctrl;
    logic [3:0] cmd;
    logic       s_bit;
    logic [1:0] alu_control;
    logic [1:0] flag_w;

    main_fsm u_main_fsm (
        .clk   (clk),
        .reset (reset),
        .op    (bus.Op),
        .funct (bus.Funct),
        .state (state),
        .ctrl  (ctrl)
    );

    assign cmd   = bus.Funct[4:1];
    assign s_bit = bus.Funct[0];

    // Only ADD/SUB touch C and V; unknown commands fall back to ADD and never set flags.
    always_comb begin
        alu_control = ALU_ADD;
        flag_w      = 2'b00;
        if (ctrl.aluop) begin
            case (cmd)
                CMD_ADD: begin
                    alu_control = ALU_ADD;
                    flag_w      = {s_bit, s_bit};
                end
                CMD_SUB: begin
                    alu_control = ALU_SUB;
                    flag_w      = {s_bit, s_bit};
                end
                CMD_AND: begin
                    alu_control = ALU_AND;
                    flag_w      = {s_bit, 1'b0};
                end
                CMD_ORR: begin
                    alu_control = ALU_ORR;
                    flag_w      = {s_bit, 1'b0};
                end
                default: begin
                    alu_control = ALU_ADD;
                    flag_w      = 2'b00;
                end
            endcase
        end
    end

    assign bus.IRWrite    = ctrl.irwrite & ~reset;
    assign bus.NextPC     = ctrl.nextpc & ~reset;
    assign bus.RegW       = ctrl.regw & ~reset;
    assign bus.MemW       = ctrl.memw & ~reset;
    assign bus.FlagW      = flag_w & {2{~reset}};
    assign bus.PCS        = ~reset & (ctrl.branch | (ctrl.regw & (bus.Rd == PC_REG)));

    assign bus.AdrSrc     = ctrl.adrsrc;
    assign bus.ResultSrc  = ctrl.resultsrc;
    assign bus.ALUSrcA    = ctrl.alusrca;
    assign bus.ALUSrcB    = ctrl.alusrcb;
    assign bus.ALUControl = alu_control;
    assign bus.ImmSrc     = bus.Op;
    assign bus.RegSrc     = {bus.Op == OP_MEM, bus.Op == OP_BR};

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for the multicycle controller: one expected control vector
// per cycle is queued when an instruction is driven, then checked cycle by cycle.
module tb_multicycle_controller;
  import arm_ctrl_pkg::*;

  logic       clk;
  logic       reset;
  statetype_t dbg_state;
  int         n_tests;
  int         n_fail;
  logic [22:0] exp_q[$];

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected vector: {state, IRWrite, NextPC, RegW, MemW, PCS, FlagW, AdrSrc,
  //                   ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc}
  function automatic logic [22:0] model(input statetype_t st, input bit rst,
                                        input logic [1:0] op, input logic [5:0] funct,
                                        input logic [3:0] rd);
    logic irw, npc, regw, memw, br, aluop, adr, sa, pcs;
    logic [1:0] rs, sb, alu, fw;
    logic [3:0] cmd;
    logic s;
    irw = 0; npc = 0; regw = 0; memw = 0; br = 0; aluop = 0; adr = 0; sa = 0;
    rs = 2'b00; sb = 2'b00; alu = 2'b00; fw = 2'b00;
    case (st)
      FETCH:    begin irw = 1; npc = 1; sa = 1; sb = 2'b10; rs = 2'b10; end
      DECODE:   begin sa = 1; sb = 2'b10; rs = 2'b10; end
      MEMADR:   sb = 2'b01;
      MEMREAD:  adr = 1;
      MEMWB:    begin rs = 2'b01; regw = 1; end
      MEMWRITE: begin adr = 1; memw = 1; end
      EXECUTER: aluop = 1;
      EXECUTEI: begin sb = 2'b01; aluop = 1; end
      ALUWB:    regw = 1;
      BRANCH:   begin sb = 2'b01; rs = 2'b10; br = 1; end
      default:  ;
    endcase
    cmd = funct[4:1];
    s   = funct[0];
    if (aluop) begin
      if (cmd == 4'b0100)      begin alu = 2'b00; fw = {s, s};    end
      else if (cmd == 4'b0010) begin alu = 2'b01; fw = {s, s};    end
      else if (cmd == 4'b0000) begin alu = 2'b10; fw = {s, 1'b0}; end
      else if (cmd == 4'b1100) begin alu = 2'b11; fw = {s, 1'b0}; end
    end
    pcs = br | (regw & (rd == 4'd15));
    if (rst) begin
      irw = 0; npc = 0; regw = 0; memw = 0; pcs = 0; fw = 2'b00;
    end
    return {st, irw, npc, regw, memw, pcs, fw, adr, rs, sa, sb, alu, op,
            (op == 2'b01), (op == 2'b10)};
  endfunction

  function automatic logic [22:0] sample();
    return {dbg_state, bus.IRWrite, bus.NextPC, bus.RegW, bus.MemW, bus.PCS, bus.FlagW,
            bus.AdrSrc, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl,
            bus.ImmSrc, bus.RegSrc};
  endfunction

  // scoreboard pop/compare
  task automatic compare(input string name);
    logic [22:0] e;
    if (exp_q.size() == 0) begin
      chk({name, "/underflow"}, exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("%s/%s", name, dbg_state.name()), sample(), e);
    end
  endtask

  // driver: called at a negedge with the DUT in FETCH
  task automatic run_instr(input string name, input logic [1:0] op,
                           input logic [5:0] funct, input logic [3:0] rd);
    statetype_t seq[$];
    bus.Op = op; bus.Funct = funct; bus.Rd = rd;
    seq.push_back(FETCH);
    seq.push_back(DECODE);
    case (op)
      2'b01: begin
        seq.push_back(MEMADR);
        if (funct[0]) begin seq.push_back(MEMREAD); seq.push_back(MEMWB); end
        else seq.push_back(MEMWRITE);
      end
      2'b00: begin
        seq.push_back(funct[5] ? EXECUTEI : EXECUTER);
        seq.push_back(ALUWB);
      end
      2'b10: seq.push_back(BRANCH);
      default: ;
    endcase
    foreach (seq[i]) exp_q.push_back(model(seq[i], 1'b0, op, funct, rd));
    foreach (seq[i]) begin
      #1;
      compare(name);
      @(negedge clk);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    bus.Op = 2'b00; bus.Funct = 6'b0; bus.Rd = 4'd0;

    // reset held three cycles: strobes low, selects at FETCH values
    repeat (3) begin
      @(negedge clk);
      #1;
      exp_q.push_back(model(FETCH, 1'b1, 2'b00, 6'b0, 4'd0));
      compare("reset");
    end
    @(negedge clk);
    reset = 1'b0;

    run_instr("ldr",     2'b01, 6'b011001, 4'd2);
    run_instr("str",     2'b01, 6'b011000, 4'd4);
    run_instr("subs",    2'b00, 6'b000101, 4'd3);
    run_instr("orrs_i",  2'b00, 6'b111001, 4'd5);
    run_instr("add_pc",  2'b00, 6'b001000, 4'd15);
    run_instr("ands",    2'b00, 6'b000001, 4'd1);
    run_instr("bad_cmd", 2'b00, 6'b001011, 4'd6);
    run_instr("ldr_pc",  2'b01, 6'b011001, 4'd15);
    run_instr("branch",  2'b10, 6'b100000, 4'd0);
    run_instr("op11",    2'b11, 6'b000000, 4'd0);
    run_instr("adds",    2'b00, 6'b001001, 4'd7);

    for (int k = 0; k < 24; k++) begin
      run_instr("rand", 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
                4'($urandom_range(0, 15)));
    end

    // reset pulsed in MEMWB of a load to PC: strobes must drop within the cycle
    bus.Op = 2'b01; bus.Funct = 6'b011001; bus.Rd = 4'd15;
    exp_q.push_back(model(FETCH,   1'b0, 2'b01, 6'b011001, 4'd15));
    exp_q.push_back(model(DECODE,  1'b0, 2'b01, 6'b011001, 4'd15));
    exp_q.push_back(model(MEMADR,  1'b0, 2'b01, 6'b011001, 4'd15));
    exp_q.push_back(model(MEMREAD, 1'b0, 2'b01, 6'b011001, 4'd15));
    exp_q.push_back(model(MEMWB,   1'b0, 2'b01, 6'b011001, 4'd15));
    repeat (4) begin
      #1;
      compare("ldr_abort");
      @(negedge clk);
    end
    #1;
    compare("ldr_abort");
    #2;
    reset = 1'b1;
    #1;
    chk("memwb_regw_drop", bus.RegW, 1'b0);
    exp_q.push_back(model(FETCH, 1'b1, 2'b01, 6'b011001, 4'd15));
    compare("mid_reset");
    @(negedge clk);
    reset = 1'b0;

    run_instr("after_rst", 2'b00, 6'b000101, 4'd9);
    #1;
    chk("final_fetch", dbg_state, FETCH);
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
